// File: rtl/bus_monitor_pkg.sv
// Shared definitions for the Z80 bus monitor: cycle-type codes, trace record
// layout, capture-FSM state encodings and the cycle-type decode helper.
package bus_monitor_pkg;

  // Cycle type codes stored in each trace record
  localparam logic [2:0] CYC_NONE   = 3'd0;
  localparam logic [2:0] CYC_FETCH  = 3'd1;
  localparam logic [2:0] CYC_MEMRD  = 3'd2;
  localparam logic [2:0] CYC_MEMWR  = 3'd3;
  localparam logic [2:0] CYC_IORD   = 3'd4;
  localparam logic [2:0] CYC_IOWR   = 3'd5;
  localparam logic [2:0] CYC_INTACK = 3'd6;

  localparam int unsigned REC_W = 27;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } trace_rec_t;

  // Capture FSM encodings
  localparam logic [1:0] CAP_RUN  = 2'd0;
  localparam logic [1:0] CAP_POST = 2'd1;
  localparam logic [1:0] CAP_HALT = 2'd2;

  // Inputs are the active-high "seen during this cycle" flags.
  // Interrupt acknowledge wins over opcode fetch since both carry M1.
  function automatic logic [2:0] decode_cycle(input logic m1, input logic rd, input logic wr,
                                              input logic iorq, input logic mreq);
    logic [2:0] t;
    if (m1 && iorq)             t = CYC_INTACK;
    else if (mreq && rd && m1)  t = CYC_FETCH;
    else if (mreq && rd)        t = CYC_MEMRD;
    else if (mreq && wr)        t = CYC_MEMWR;
    else if (iorq && rd)        t = CYC_IORD;
    else if (iorq && wr)        t = CYC_IOWR;
    else                        t = CYC_NONE;
    return t;
  endfunction

endpackage

// File: rtl/z80_cycle_classifier.sv
// Z80 bus-cycle classifier. Tracks each MREQ/IORQ cycle (refresh excluded),
// latching address/data every clock while active so the final sample before
// release is kept, and raises commit_req combinationally on the release sample.
// Ports: clk_cpu, reset_cpu (async, active-low), CPU bus a_cpu/d_cpu and
// L-active strobes; commit_req and the completed record rec.
module z80_cycle_classifier
  import bus_monitor_pkg::*;
(
  input  logic        clk_cpu,
  input  logic        reset_cpu,
  input  logic [15:0] a_cpu,
  input  logic [7:0]  d_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  input  logic        io_req_cpu,
  input  logic        mem_req_cpu,
  input  logic        m1_cpu,
  input  logic        rfsh_cpu,
  output logic        commit_req,
  output trace_rec_t  rec
);

  localparam logic CLS_IDLE   = 1'b0;
  localparam logic CLS_ACTIVE = 1'b1;

  logic        state_q, state_d;
  logic        req, latch, clear;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        m1_seen_q, rd_seen_q, wr_seen_q, io_seen_q, mem_seen_q;
  logic [2:0]  typ;

  assign req = ~mem_req_cpu | ~io_req_cpu;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      CLS_IDLE: begin
        // rfsh_cpu low marks a refresh cycle, which is never traced
        if (req && rfsh_cpu) begin
          state_d = CLS_ACTIVE;
          latch   = 1'b1;
          clear   = 1'b1;
        end
      end
      default: begin
        if (!req) state_d = CLS_IDLE;
        else      latch   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_cpu or negedge reset_cpu) begin
    if (!reset_cpu) begin
      state_q    <= CLS_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      m1_seen_q  <= 1'b0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      io_seen_q  <= 1'b0;
      mem_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q     <= a_cpu;
        data_q     <= d_cpu;
        // Strobe flags are sticky across the cycle, restarted on entry
        m1_seen_q  <= (m1_seen_q & ~clear) | ~m1_cpu;
        rd_seen_q  <= (rd_seen_q & ~clear) | ~rd_cpu;
        wr_seen_q  <= (wr_seen_q & ~clear) | ~wr_cpu;
        io_seen_q  <= (io_seen_q & ~clear) | ~io_req_cpu;
        mem_seen_q <= (mem_seen_q & ~clear) | ~mem_req_cpu;
      end
    end
  end

  assign typ = decode_cycle(m1_seen_q, rd_seen_q, wr_seen_q, io_seen_q, mem_seen_q);

  // Cycles that never showed RD/WR (and are not int ack) decode to NONE and are dropped
  assign commit_req = (state_q == CLS_ACTIVE) && !req && (typ != CYC_NONE);
  assign rec        = {typ, addr_q, data_q};

endmodule

// File: rtl/z80_cycle_tracer.sv
// Z80 bus-cycle tracer: ring buffer of completed bus-cycle records with a
// registered read port (rd_idx 0 = newest) and an optional address trigger.
// Optional feature macro: TRACE_TRIGGER_EN (trigger comparator, POST/HALT
// capture states, triggered/halted outputs). Without it capture always runs.
// Ports: clk_cpu, reset_cpu (async, active-low), CPU bus inputs, arm/freeze
// controls, trig_addr/post_cnt, rd_idx; record outputs rec_addr/rec_data/
// rec_type, rec_count, commit, triggered, halted.
module z80_cycle_tracer
  import bus_monitor_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_cpu,
  input  logic          reset_cpu,
  input  logic [15:0]   a_cpu,
  input  logic [7:0]    d_cpu,
  input  logic          wr_cpu,
  input  logic          rd_cpu,
  input  logic          io_req_cpu,
  input  logic          mem_req_cpu,
  input  logic          m1_cpu,
  input  logic          rfsh_cpu,
  input  logic          arm,
  input  logic          freeze,
  input  logic [15:0]   trig_addr,
  input  logic [AW-1:0] post_cnt,
  input  logic [AW-1:0] rd_idx,
  output logic [15:0]   rec_addr,
  output logic [7:0]    rec_data,
  output logic [2:0]    rec_type,
  output logic [AW:0]   rec_count,
  output logic          commit,
  output logic          triggered,
  output logic          halted
);

  trace_rec_t    cls_rec;
  logic          commit_req;
  logic          wr_en;
  logic [REC_W-1:0] buf_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          commit_q;
  trace_rec_t    rd_q;

  z80_cycle_classifier u_classifier (
    .clk_cpu     (clk_cpu),
    .reset_cpu   (reset_cpu),
    .a_cpu       (a_cpu),
    .d_cpu       (d_cpu),
    .wr_cpu      (wr_cpu),
    .rd_cpu      (rd_cpu),
    .io_req_cpu  (io_req_cpu),
    .mem_req_cpu (mem_req_cpu),
    .m1_cpu      (m1_cpu),
    .rfsh_cpu    (rfsh_cpu),
    .commit_req  (commit_req),
    .rec         (cls_rec)
  );

`ifdef TRACE_TRIGGER_EN
  logic [1:0]    cap_q;
  logic [AW-1:0] remain_q;
  logic          trig_q, halt_q;

  // arm beats a coincident commit; freeze holds both storage and countdown
  assign wr_en = commit_req & ~freeze & ~arm & (cap_q != CAP_HALT);

  always_ff @(posedge clk_cpu or negedge reset_cpu) begin
    if (!reset_cpu) begin
      cap_q    <= CAP_RUN;
      remain_q <= '0;
      trig_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else if (arm) begin
      cap_q    <= CAP_RUN;
      remain_q <= '0;
      trig_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else if (wr_en) begin
      case (cap_q)
        CAP_RUN: begin
          if (cls_rec.addr == trig_addr) begin
            trig_q <= 1'b1;
            if (post_cnt == '0) begin
              cap_q  <= CAP_HALT;
              halt_q <= 1'b1;
            end else begin
              cap_q    <= CAP_POST;
              remain_q <= post_cnt;
            end
          end
        end
        CAP_POST: begin
          remain_q <= remain_q - AW'(1);
          if (remain_q == AW'(1)) begin
            cap_q  <= CAP_HALT;
            halt_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign triggered = trig_q;
  assign halted    = halt_q;
`else
  logic unused_trig;

  assign wr_en       = commit_req & ~freeze & ~arm;
  assign triggered   = 1'b0;
  assign halted      = 1'b0;
  assign unused_trig = ^{trig_addr, post_cnt};
`endif

  always_ff @(posedge clk_cpu) begin
    if (wr_en) buf_q[wr_ptr_q] <= cls_rec;
  end

  always_ff @(posedge clk_cpu or negedge reset_cpu) begin
    if (!reset_cpu) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
    end else if (arm) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= wr_en;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != (AW+1)'(DEPTH)) count_q <= count_q + (AW+1)'(1);
      end
    end
  end

  // Newest record sits just behind the write pointer
  assign rd_ptr = wr_ptr_q - AW'(1) - rd_idx;

  always_ff @(posedge clk_cpu or negedge reset_cpu) begin
    if (!reset_cpu) begin
      rd_q <= '0;
    end else if ({1'b0, rd_idx} < count_q) begin
      rd_q <= buf_q[rd_ptr];
    end else begin
      rd_q <= '0;
    end
  end

  assign rec_type  = rd_q.typ;
  assign rec_addr  = rd_q.addr;
  assign rec_data  = rd_q.data;
  assign rec_count = count_q;
  assign commit    = commit_q;

endmodule

// File: doc/z80_cycle_tracer.md
# z80_cycle_tracer

- Captures each completed Z80 bus cycle as an {address, data, cycle type} record into a ring buffer.
- Sits downstream of the bus monitor's CPU-side bus inputs, in parallel with the PIO register file.
- Single-step mode can then walk back through recent bus history on the 7-segment muxer.
- An optional address trigger stops capture a programmable number of cycles after a match.

## Interface
- DEPTH, 16, ring buffer entries (power of two, 4..64); AW = log2(DEPTH)
- clk_cpu  in  1  Z80 clock; all logic on posedge
- reset_cpu  in  1  asynchronous, active-low reset
- a_cpu  in  16  CPU address bus
- d_cpu  in  8  CPU data bus
- wr_cpu, rd_cpu, io_req_cpu, mem_req_cpu, m1_cpu, rfsh_cpu  in  1 each  CPU strobes, L-active
- arm  in  1  H for one clk: clear buffer, restart capture
- freeze  in  1  H: suppress commits (step mode hold)
- trig_addr  in  16  trigger address (TRACE_TRIGGER_EN only)
- post_cnt  in  AW  records to capture after trigger (TRACE_TRIGGER_EN only)
- rd_idx  in  AW  read index, 0 = newest record
- rec_addr  out  16  addressed record, address
- rec_data  out  8  addressed record, data
- rec_type  out  3  addressed record, cycle type
- rec_count  out  AW+1  valid records, saturates at DEPTH
- commit  out  1  H for one clk when a record is written
- triggered  out  1  H once trigger matched
- halted  out  1  H when capture stopped by post-trigger completion

## Operation
Cycle type encoding:
- 0 empty
- 1 opcode fetch: M1 & MREQ & RD
- 2 mem read: MREQ & RD & !M1
- 3 mem write: MREQ & WR
- 4 io read: IORQ & RD
- 5 io write: IORQ & WR
- 6 int ack: M1 & IORQ

Classifier FSM, states IDLE and ACTIVE:
- IDLE -> ACTIVE: on a sample where mem_req_cpu or io_req_cpu is low and rfsh_cpu is high. Refresh cycles are never recorded.
- In ACTIVE, every clk: latch a_cpu, d_cpu and type. The last sample before release is what gets stored.
- ACTIVE -> IDLE: on the first sample with mem_req_cpu and io_req_cpu both high. A commit request is raised on that clk.
- Type 6 overrides type 1. A cycle with no RD/WR ever seen and not type 6 is dropped.

Capture FSM, states RUN, POST, HALT:
- Reset or arm -> RUN: write pointer 0, rec_count 0, triggered 0, halted 0.
- RUN: a commit writes the record at the write pointer, then pointer +1 modulo DEPTH (wrap overwrites oldest). rec_count +1, saturating at DEPTH.
- RUN -> POST (TRACE_TRIGGER_EN): on a committed record with address == trig_addr. triggered=1; the matching record is stored. Remaining = post_cnt.
- POST: each commit stores the record and decrements remaining. POST -> HALT after the commit that takes remaining to 0. post_cnt = 0 means HALT immediately after the trigger record.
- HALT: no commits; halted=1 until arm or reset.

Boundary rules:
- freeze high: the commit request is discarded, commit stays 0, and the POST countdown does not advance.
- arm coincident with a commit request: arm wins, the record is discarded.
- Reset asserted mid-cycle: classifier returns to IDLE, the partial cycle is lost.
- Read address = (write pointer - 1 - rd_idx) mod DEPTH.
- rd_idx >= rec_count: rec_type=0, rec_addr=0, rec_data=0.

## Timing
- Reset values:
  - rec_addr=0, rec_data=0, rec_type=0
  - rec_count=0
  - commit=0, triggered=0, halted=0
- Commit latency: commit pulses on the first posedge that samples both request strobes high. The record is readable at rd_idx 0 one clk later.
- Read port is registered with 1-clk latency from rd_idx or buffer change.
- triggered asserts on the same clk as the trigger record's commit. halted asserts on the clk of the final post commit.
- Back-to-back cycles (IORQ released, MREQ asserted on the next sample) yield two commits with no gap requirement.

## Configuration
- TRACE_TRIGGER_EN defined: trigger comparator, POST/HALT states, trig_addr/post_cnt/triggered/halted all functional.
- TRACE_TRIGGER_EN undefined: capture FSM is RUN only, trig_addr and post_cnt are ignored, triggered and halted are tied 0.

## Structure
- Shared package bus_monitor_pkg holds:
  - cycle type constants CYC_NONE..CYC_INTACK (3 bits)
  - record width constant (27 bits)
  - capture state encodings
- Sub-module z80_cycle_classifier contains the IDLE/ACTIVE FSM, latching, type decode and commit request.
- The top level holds the ring buffer (distributed RAM or register array), pointers, capture FSM and read port.

## Test plan
- Mem write 0x1234 <- 0xA5, then io read port 0x80 = 0x3C: rd_idx0 = {4,0x0080,0x3C}, rd_idx1 = {3,0x1234,0xA5}, rec_count=2.
- Opcode fetch at 0x0100 followed by a refresh cycle (rfsh_cpu low, mem_req_cpu low): exactly one record {1,0x0100,op}, commit pulses once.
- DEPTH+3 mem reads at addresses 0..DEPTH+2: rec_count=DEPTH, rd_idx0 addr DEPTH+2, rd_idx DEPTH-1 addr 3.
- TRACE_TRIGGER_EN, trig_addr=0x0038, post_cnt=2, cycles at 0x0030, 0x0038, 0x0039, 0x003A, 0x003B:
  - triggered on the 0x0038 commit
  - halted after 0x003A; 0x003B is not stored
  - rd_idx0 = 0x003A
- freeze high for 3 io writes, then low for 1 io write: only the last is stored, rec_count=1.
- Reset low during an active mem read, released, then one io write to 0x81: rec_count=1, record type 5, address 0x0081.
